// File: rtl/cnn_accel_pkg.sv
// Shared CNN accelerator definitions: tile sequencer FSM encoding and
// elaboration-time helpers for derived tile geometry.
//   calc_ro / calc_co : output rows / cols of a K x K, stride-S window sweep
//   calc_nrd          : bank reads per tile, (Tm/4)*K*K*RO*CO
//   clog2_u           : ceil(log2(v)), 0 for v <= 1
package cnn_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } fsm_state_e;

  function automatic int unsigned calc_ro(input int unsigned tr, input int unsigned k,
                                          input int unsigned s);
    return (tr - k) / s + 1;
  endfunction

  function automatic int unsigned calc_co(input int unsigned tc, input int unsigned k,
                                          input int unsigned s);
    return (tc - k) / s + 1;
  endfunction

  function automatic int unsigned calc_nrd(input int unsigned tm, input int unsigned k,
                                           input int unsigned ro, input int unsigned co);
    return (tm / 4) * k * k * ro * co;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/in_fm_addr_gen.sv
// Nested read-pattern counters for the input feature-map banks.
// Loop order outermost first: g, kr, kc, r, c. The address is built from
// incremental base registers so no runtime multiplier is needed.
//   clk, rst : clock, synchronous active-low reset
//   clr_i    : clear all counters and bases
//   step_i   : advance to the next address
//   addr_c   : current address g*Tr*Tc + (r*S+kr)*Tc + (c*S+kc)
//   first_c  : all counters at zero
//   last_c   : all counters at their maximum
//   wrap_c   : final address consumed this cycle (step_i && last_c)
module in_fm_addr_gen
  import cnn_accel_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned Tm = 16,
  parameter int unsigned Tr = 64,
  parameter int unsigned Tc = 16,
  parameter int unsigned K  = 3,
  parameter int unsigned S  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_c,
  output logic          first_c,
  output logic          last_c,
  output logic          wrap_c
);

  localparam int unsigned RO    = calc_ro(Tr, K, S);
  localparam int unsigned CO    = calc_co(Tc, K, S);
  localparam int unsigned NG    = Tm / 4;
  localparam int unsigned MAXA  = (NG > K) ? NG : K;
  localparam int unsigned MAXB  = (RO > CO) ? RO : CO;
  localparam int unsigned MAXC  = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int unsigned CW    = (clog2_u(MAXC) < 1) ? 1 : clog2_u(MAXC);

  localparam logic [AW-1:0] G_STEP  = AW'(Tr * Tc);
  localparam logic [AW-1:0] KR_STEP = AW'(Tc);
  localparam logic [AW-1:0] R_STEP  = AW'(S * Tc);
  localparam logic [AW-1:0] C_STEP  = AW'(S);

  logic [CW-1:0] g_q, g_d, kr_q, kr_d, kc_q, kc_d, r_q, r_d, c_q, c_d;
  logic [AW-1:0] g_base_q, g_base_d, kr_base_q, kr_base_d;
  logic [AW-1:0] row_base_q, row_base_d, col_q, col_d;
  logic          c_end, r_end, kc_end, kr_end, g_end;

  assign c_end  = (c_q  == CW'(CO - 1));
  assign r_end  = (r_q  == CW'(RO - 1));
  assign kc_end = (kc_q == CW'(K - 1));
  assign kr_end = (kr_q == CW'(K - 1));
  assign g_end  = (g_q  == CW'(NG - 1));

  assign addr_c  = g_base_q + kr_base_q + AW'(kc_q) + row_base_q + col_q;
  assign first_c = (g_q == '0) && (kr_q == '0) && (kc_q == '0) && (r_q == '0) && (c_q == '0);
  assign last_c  = c_end && r_end && kc_end && kr_end && g_end;
  assign wrap_c  = step_i && last_c;

  // Ripple-carry style update: an inner counter at max clears and carries outward.
  always_comb begin
    g_d        = g_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    r_d        = r_q;
    c_d        = c_q;
    g_base_d   = g_base_q;
    kr_base_d  = kr_base_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    if (clr_i) begin
      g_d        = '0;
      kr_d       = '0;
      kc_d       = '0;
      r_d        = '0;
      c_d        = '0;
      g_base_d   = '0;
      kr_base_d  = '0;
      row_base_d = '0;
      col_d      = '0;
    end else if (step_i) begin
      if (c_end) begin
        c_d   = '0;
        col_d = '0;
        if (r_end) begin
          r_d        = '0;
          row_base_d = '0;
          if (kc_end) begin
            kc_d = '0;
            if (kr_end) begin
              kr_d      = '0;
              kr_base_d = '0;
              if (g_end) begin
                g_d      = '0;
                g_base_d = '0;
              end else begin
                g_d      = g_q + CW'(1);
                g_base_d = g_base_q + G_STEP;
              end
            end else begin
              kr_d      = kr_q + CW'(1);
              kr_base_d = kr_base_q + KR_STEP;
            end
          end else begin
            kc_d = kc_q + CW'(1);
          end
        end else begin
          r_d        = r_q + CW'(1);
          row_base_d = row_base_q + R_STEP;
        end
      end else begin
        c_d   = c_q + CW'(1);
        col_d = col_q + C_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      g_q        <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      g_base_q   <= '0;
      kr_base_q  <= '0;
      row_base_q <= '0;
      col_q      <= '0;
    end else begin
      g_q        <= g_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      r_q        <= r_d;
      c_q        <= c_d;
      g_base_q   <= g_base_d;
      kr_base_q  <= kr_base_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: rtl/in_fm_tile_ctrl.sv
// Tile-level sequencer for the 4-bank input feature-map buffer: resets the
// buffer, starts and waits for its load, then sweeps the convolution read
// pattern on all four bank address ports.
//   clk, rst          : clock, synchronous active-low reset
//   tile_start        : begin a tile (ignored unless idle)
//   tile_done         : 1-cycle pulse in DONE, with the last read's data valid
//   busy              : tile in progress
//   conv_tile_reset   : 1-cycle pulse to the buffer counters
//   in_fm_load_start  : 1-cycle pulse starting the buffer load
//   in_fm_load_done   : buffer load complete (level)
//   stall             : PE back-pressure, freezes the read sweep
//   rd_addr0..3       : bank read addresses (identical)
//   rd_valid          : bank read data valid (1 cycle after the address)
//   acc_first/last    : first / last read of the tile, aligned with rd_valid
module in_fm_tile_ctrl
  import cnn_accel_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned Tm = 16,
  parameter int unsigned Tr = 64,
  parameter int unsigned Tc = 16,
  parameter int unsigned K  = 3,
  parameter int unsigned S  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tile_start,
  output logic          tile_done,
  output logic          busy,
  output logic          conv_tile_reset,
  output logic          in_fm_load_start,
  input  logic          in_fm_load_done,
  input  logic          stall,
  output logic [AW-1:0] rd_addr0,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] rd_addr2,
  output logic [AW-1:0] rd_addr3,
  output logic          rd_valid,
  output logic          acc_first,
  output logic          acc_last
);

  localparam int unsigned NRD  = calc_nrd(Tm, K, calc_ro(Tr, K, S), calc_co(Tc, K, S));
  localparam logic [63:0] FOOT = 64'(Tm / 4) * 64'(Tr) * 64'(Tc);

  if ((Tm % 4) != 0 || Tm == 0 || NRD == 0 || FOOT > (64'd1 << AW)) begin : g_param_chk
    $error("in_fm_tile_ctrl: tile does not fit the bank address space");
  end

  fsm_state_e    state_q, state_d;
  logic          step_c;
  logic [AW-1:0] addr_c;
  logic          first_c, last_c, wrap_c;

  logic          tile_done_q, tile_done_d, busy_q, busy_d;
  logic          conv_rst_q, conv_rst_d, load_start_q, load_start_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          iss_q, iss_d, first_q, first_d, last_q, last_d;
  logic          rd_valid_q, rd_valid_d, acc_first_q, acc_first_d, acc_last_q, acc_last_d;

  assign step_c = (state_q == ST_READ) && !stall;

  in_fm_addr_gen #(
    .AW (AW),
    .Tm (Tm),
    .Tr (Tr),
    .Tc (Tc),
    .K  (K),
    .S  (S)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == ST_RST),
    .step_i  (step_c),
    .addr_c  (addr_c),
    .first_c (first_c),
    .last_c  (last_c),
    .wrap_c  (wrap_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state; load_done is stale during the first LOAD cycle (load_start_q high)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tile_start) state_d = ST_RST;
      ST_RST:   state_d = ST_LOAD;
      ST_LOAD:  if (!load_start_q && in_fm_load_done) state_d = ST_READ;
      ST_READ:  if (wrap_c) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next values; the valid/flag pair is a 2-stage pipe (address, then data)
  always_comb begin
    conv_rst_d   = (state_d == ST_RST);
    load_start_d = (state_q == ST_RST);
    busy_d       = (state_d != ST_IDLE);
    tile_done_d  = (state_d == ST_DONE);
    rd_addr_d    = step_c ? addr_c : rd_addr_q;
    iss_d        = step_c;
    first_d      = step_c && first_c;
    last_d       = step_c && last_c;
    rd_valid_d   = iss_q;
    acc_first_d  = first_q;
    acc_last_d   = last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conv_rst_q   <= 1'b0;
      load_start_q <= 1'b0;
      busy_q       <= 1'b0;
      tile_done_q  <= 1'b0;
      rd_addr_q    <= '0;
      iss_q        <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      acc_first_q  <= 1'b0;
      acc_last_q   <= 1'b0;
    end else begin
      conv_rst_q   <= conv_rst_d;
      load_start_q <= load_start_d;
      busy_q       <= busy_d;
      tile_done_q  <= tile_done_d;
      rd_addr_q    <= rd_addr_d;
      iss_q        <= iss_d;
      first_q      <= first_d;
      last_q       <= last_d;
      rd_valid_q   <= rd_valid_d;
      acc_first_q  <= acc_first_d;
      acc_last_q   <= acc_last_d;
    end
  end

  assign tile_done        = tile_done_q;
  assign busy             = busy_q;
  assign conv_tile_reset  = conv_rst_q;
  assign in_fm_load_start = load_start_q;
  assign rd_addr0         = rd_addr_q;
  assign rd_addr1         = rd_addr_q;
  assign rd_addr2         = rd_addr_q;
  assign rd_addr3         = rd_addr_q;
  assign rd_valid         = rd_valid_q;
  assign acc_first        = acc_first_q;
  assign acc_last         = acc_last_q;

endmodule

// File: tb/tb_in_fm_tile_ctrl.sv
// Bench for in_fm_tile_ctrl: instance 0 uses Tm=4,Tr=4,Tc=4,K=3,S=1 (36 reads),
// instance 1 uses Tm=8 (72 reads). Expected reads are queued at tile start and
// a negedge monitor pops one per rd_valid.
module tb_in_fm_tile_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic        first;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0] ts, ld;
  logic st;

  logic [1:0]            m_done, m_busy, m_crst, m_lstart, m_valid, m_first, m_last;
  logic [1:0][3:0][15:0] m_addr;
  logic [1:0][3:0][15:0] prev_a;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid[2];
  int   n_done[2];
  int   addr37[2];
  int   last_addr[2];

  in_fm_tile_ctrl #(.AW(16), .Tm(4), .Tr(4), .Tc(4), .K(3), .S(1)) u_dut4 (
    .clk              (clk),
    .rst              (rst),
    .tile_start       (ts[0]),
    .tile_done        (m_done[0]),
    .busy             (m_busy[0]),
    .conv_tile_reset  (m_crst[0]),
    .in_fm_load_start (m_lstart[0]),
    .in_fm_load_done  (ld[0]),
    .stall            (st),
    .rd_addr0         (m_addr[0][0]),
    .rd_addr1         (m_addr[0][1]),
    .rd_addr2         (m_addr[0][2]),
    .rd_addr3         (m_addr[0][3]),
    .rd_valid         (m_valid[0]),
    .acc_first        (m_first[0]),
    .acc_last         (m_last[0])
  );

  in_fm_tile_ctrl #(.AW(16), .Tm(8), .Tr(4), .Tc(4), .K(3), .S(1)) u_dut8 (
    .clk              (clk),
    .rst              (rst),
    .tile_start       (ts[1]),
    .tile_done        (m_done[1]),
    .busy             (m_busy[1]),
    .conv_tile_reset  (m_crst[1]),
    .in_fm_load_start (m_lstart[1]),
    .in_fm_load_done  (ld[1]),
    .stall            (1'b0),
    .rd_addr0         (m_addr[1][0]),
    .rd_addr1         (m_addr[1][1]),
    .rd_addr2         (m_addr[1][2]),
    .rd_addr3         (m_addr[1][3]),
    .rd_valid         (m_valid[1]),
    .acc_first        (m_first[1]),
    .acc_last         (m_last[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference read order: nested loops with plain multiplies.
  task automatic push_tile(input int d, input int tm);
    exp_t e;
    for (int g = 0; g < tm / 4; g++)
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++)
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
              e.addr  = 16'(g * 16 + (r + kr) * 4 + (c + kc));
              e.first = (g == 0 && kr == 0 && kc == 0 && r == 0 && c == 0);
              e.last  = (g == tm / 4 - 1 && kr == 2 && kc == 2 && r == 1 && c == 1);
              if (d == 0) q0.push_back(e);
              else        q1.push_back(e);
            end
  endtask

  // Monitor: address of a valid read is the one presented the cycle before.
  always @(negedge clk) begin
    exp_t e;
    int   qs;
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d]) begin
        qs = (d == 0) ? q0.size() : q1.size();
        check($sformatf("sb_nonempty[%0d]", d), 32'(qs != 0), 32'd1);
        if (qs != 0) begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          for (int k = 0; k < 4; k++)
            check($sformatf("rd_addr%0d[%0d] #%0d", k, d, n_valid[d]),
                  32'(prev_a[d][k]), 32'(e.addr));
          check($sformatf("acc_first[%0d] #%0d", d, n_valid[d]), 32'(m_first[d]), 32'(e.first));
          check($sformatf("acc_last[%0d] #%0d", d, n_valid[d]), 32'(m_last[d]), 32'(e.last));
        end
        if (n_valid[d] == 36) addr37[d] = 32'(prev_a[d][0]);
        last_addr[d] = 32'(prev_a[d][0]);
        n_valid[d]++;
      end
      if (m_done[d]) n_done[d]++;
      prev_a[d] = m_addr[d];
    end
  end

  task automatic start_tile(input int d, input int tm);
    n_valid[d] = 0;
    n_done[d]  = 0;
    push_tile(d, tm);
    ts[d] = 1'b1;
    cyc(1);
    ts[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc(1);
      seen = m_done[d];
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    cyc(3);
  endtask

  task automatic end_tile(input int d, input int nexp, input string name);
    int qs;
    qs = (d == 0) ? q0.size() : q1.size();
    check({name, "_valids"}, 32'(n_valid[d]), 32'(nexp));
    check({name, "_dones"}, 32'(n_done[d]), 32'd1);
    check({name, "_queue_left"}, 32'(qs), 32'd0);
    check({name, "_busy_after"}, 32'(m_busy[d]), 32'd0);
  endtask

  task automatic run_plain(input int d, input int tm, input string name);
    start_tile(d, tm);
    cyc(3);
    ld[d] = 1'b1;
    wait_done(d, name);
    end_tile(d, (tm / 4) * 36, name);
    ld[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0; ts = '0; ld = '0; st = 1'b0;
    n_valid = '{0, 0}; n_done = '{0, 0}; addr37 = '{0, 0}; last_addr = '{0, 0};
    cyc(3);
    check("rst_busy", 32'(m_busy[0]), 32'd0);
    check("rst_rd_valid", 32'(m_valid[0]), 32'd0);
    check("rst_rd_addr0", 32'(m_addr[0][0]), 32'd0);
    check("rst_tile_done", 32'(m_done[0]), 32'd0);
    check("rst_conv_reset", 32'(m_crst[0]), 32'd0);
    check("rst_load_start", 32'(m_lstart[0]), 32'd0);
    check("rst_acc_first", 32'(m_first[0]), 32'd0);
    check("rst_acc_last", 32'(m_last[0]), 32'd0);
    rst = 1'b1;
    cyc(2);

    // 1: basic tile, load_done 5 cycles after load_start
    start_tile(0, 4);
    check("t1_conv_reset", 32'(m_crst[0]), 32'd1);
    check("t1_busy", 32'(m_busy[0]), 32'd1);
    check("t1_load_start_early", 32'(m_lstart[0]), 32'd0);
    cyc(1);
    check("t1_load_start", 32'(m_lstart[0]), 32'd1);
    check("t1_conv_reset_off", 32'(m_crst[0]), 32'd0);
    cyc(1);
    check("t1_load_start_pulse", 32'(m_lstart[0]), 32'd0);
    cyc(4);
    ld[0] = 1'b1;
    wait_done(0, "t1");
    end_tile(0, 36, "t1");
    check("t1_last_addr", 32'(last_addr[0]), 32'd15);
    ld[0] = 1'b0;

    // 2: stall for 3 cycles once the 6th address (2) is presented
    start_tile(0, 4);
    cyc(1);
    check("t2_load_start", 32'(m_lstart[0]), 32'd1);
    cyc(2);
    ld[0] = 1'b1;
    cyc(1);
    cyc(6);
    st = 1'b1;
    cyc(1);
    check("t2_hold_addr_a", 32'(m_addr[0][0]), 32'd2);
    check("t2_valid_before_gap", 32'(m_valid[0]), 32'd1);
    cyc(1);
    check("t2_hold_addr_b", 32'(m_addr[0][0]), 32'd2);
    check("t2_gap_a", 32'(m_valid[0]), 32'd0);
    cyc(1);
    check("t2_hold_addr_c", 32'(m_addr[0][0]), 32'd2);
    check("t2_gap_b", 32'(m_valid[0]), 32'd0);
    st = 1'b0;
    cyc(1);
    check("t2_gap_c", 32'(m_valid[0]), 32'd0);
    check("t2_resume_addr", 32'(m_addr[0][0]), 32'd5);
    cyc(1);
    check("t2_valid_resume", 32'(m_valid[0]), 32'd1);
    wait_done(0, "t2");
    end_tile(0, 36, "t2");
    ld[0] = 1'b0;

    // 3: stale load_done high before the tile starts
    ld[0] = 1'b1;
    cyc(2);
    start_tile(0, 4);
    cyc(1);
    check("t3_load_start", 32'(m_lstart[0]), 32'd1);
    k = 0;
    while (k < 20) begin
      cyc(1);
      k++;
      if (m_valid[0]) break;
    end
    check("t3_first_valid_latency", 32'(k), 32'd4);
    wait_done(0, "t3");
    end_tile(0, 36, "t3");
    ld[0] = 1'b0;

    // 4: tile_start pulsed again mid-READ is ignored
    start_tile(0, 4);
    cyc(3);
    ld[0] = 1'b1;
    cyc(12);
    ts[0] = 1'b1;
    cyc(1);
    ts[0] = 1'b0;
    wait_done(0, "t4");
    end_tile(0, 36, "t4");
    cyc(10);
    check("t4_no_second_tile_busy", 32'(m_busy[0]), 32'd0);
    check("t4_no_second_done", 32'(n_done[0]), 32'd1);
    check("t4_no_extra_valid", 32'(n_valid[0]), 32'd36);
    ld[0] = 1'b0;

    // 5: one-cycle reset mid-READ, then a full tile
    start_tile(0, 4);
    cyc(3);
    ld[0] = 1'b1;
    cyc(10);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check("t5_busy", 32'(m_busy[0]), 32'd0);
    check("t5_rd_valid", 32'(m_valid[0]), 32'd0);
    check("t5_rd_addr0", 32'(m_addr[0][0]), 32'd0);
    check("t5_acc_first", 32'(m_first[0]), 32'd0);
    check("t5_acc_last", 32'(m_last[0]), 32'd0);
    check("t5_tile_done", 32'(m_done[0]), 32'd0);
    q0.delete();
    ld[0] = 1'b0;
    cyc(5);
    check("t5_no_done_after_rst", 32'(n_done[0]), 32'd0);
    check("t5_idle_after_rst", 32'(m_busy[0]), 32'd0);
    check("t5_no_valid_after_rst", 32'(m_valid[0]), 32'd0);
    run_plain(0, 4, "t5");

    // 6: two channel groups
    run_plain(1, 8, "t6");
    check("t6_group1_first_addr", 32'(addr37[1]), 32'd16);
    check("t6_last_addr", 32'(last_addr[1]), 32'd31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
